msrv32_imem_ahb_responder: RTL
==============================

// Module: msrv32_imem_ahb_responder
// PURPOSE
//  AHB-Lite read-only instruction-memory responder: the slave end of the core's fetch port.
//  Accepts address phases from the fetch master (HADDR from the PC path), reads a sync SRAM.
//  Returns HRDATA/HREADYOUT/HRESP, with programmable wait states and two-cycle ERROR.
//  Sits between the AHB instruction bus and the boot/instruction SRAM macro.
// PARAMETERS
//  ADDR_W       10           word-address width of the SRAM (depth = 2**ADDR_W words)
//  BASE_ADDR    32'h00000000 byte base of the memory window (= boot address)
//  WAIT_STATES  0            extra HREADYOUT-low cycles per OKAY transfer (0..15)
// PORTS
//  clk_in           in   1       system clock, all state on rising edge
//  rst_n_in         in   1       asynchronous, active-low reset
//  hsel_in          in   1       slave select
//  haddr_in         in   32      byte address (address phase)
//  htrans_in        in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite_in        in   1       1 = write (illegal, gets ERROR)
//  hsize_in         in   3       only 3'b010 (word) is legal
//  hready_in        in   1       bus HREADY; address phase taken only when high
//  hrdata_out       out  32      read data, valid when OKAY transfer completes
//  hreadyout_out    out  1       0 = extend current data phase
//  hresp_out        out  1       0 OKAY, 1 ERROR
//  mem_en_out       out  1       SRAM read enable (combinational)
//  mem_addr_out     out  ADDR_W  SRAM word address (combinational)
//  mem_rdata_in     in   32      SRAM data, 1-cycle latency, held until next mem_en
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, wait counter 0, hreadyout=1, hresp=0, hrdata=0.
//  - accept = hsel & hready_in & htrans[1]. Legal = !hwrite & haddr[1:0]==0 & hsize==010
//    & BASE_ADDR <= haddr < BASE_ADDR + 4*2**ADDR_W.
//  - Legal accept: mem_en_out=1, mem_addr_out=(haddr-BASE_ADDR)[ADDR_W+1:2] same cycle.
//    Next state DATA with counter=WAIT_STATES. Illegal accept: no mem_en, next state ERR1.
//  - IDLE/BUSY with hsel, or hsel low: no transfer; stays/returns IDLE, hreadyout=1, hresp=0.
//  - DATA: hreadyout = (counter==0); counter decrements each cycle while >0; hresp=0.
//    When counter==0: hrdata_out=mem_rdata_in. Next state from accept/legal (pipelined back-to-back).
//    Zero-wait latency: address phase cycle N -> data on cycle N+1.
//  - ERR1: hreadyout=0, hresp=1; always -> ERR2. ERR2: hreadyout=1, hresp=1; then accept rules.
//  - hrdata_out=0 in all states except a completing DATA cycle.
//  - Master switching to IDLE during ERR2 is legal; it is decoded normally.
//  - hready_in is low while this slave stalls. A new accept can occur only on the cycle this
//    slave drives hreadyout=1 (DATA count 0, ERR2, IDLE). mem_en for next read then overlaps
//    final data cycle; SRAM output changes after the edge, so current data is unaffected.
//  - Address inputs ignored in DATA when counter>0 and in ERR1.
//  - rst_n_in low mid-transfer: immediate return to reset values; no mem_en until release.
//  - Address-range check uses 33-bit compare; BASE_ADDR+size wrap past 2**32 = out of range.
// STRUCTURE
//  - Shared package msrv32_ahb_pkg: HTRANS_* codes, HSIZE_WORD, HRESP_OKAY/ERROR, state encoding.
//  - Flat module: 2-bit state reg, 4-bit wait counter, decode comb block, output comb block.
//  - No sub-module; SRAM macro instantiated by parent.
// TESTING
//  1 W=0, NONSEQ 0x0 then SEQ 0x4 back-to-back, SRAM[0]=0x00000013, [1]=0x00100093
//    -> hreadyout stays 1; hrdata 0x00000013 on N+1 and 0x00100093 on N+2, hresp=0.
//  2 W=2, NONSEQ 0x8 -> hreadyout 0,0,1 on N+1..N+3; hrdata=SRAM[2] only on N+3; one mem_en.
//  3 NONSEQ 0x6 (misaligned), and separately hwrite=1 to 0x0
//    -> ERR1 (ready0,resp1), ERR2 (ready1,resp1); mem_en never asserted.
//  4 ADDR_W=10, NONSEQ 0x1000 (one past end) -> ERROR; 0xFFC -> OKAY with SRAM[1023].
//  5 IDLE/BUSY and hsel=0 with hready_in=1 -> hreadyout=1, hresp=0, mem_en=0, hrdata=0.
//  6 W=3, assert rst_n_in low during second wait cycle
//    -> outputs reset values same cycle; after release, NONSEQ 0x0 completes normally.

Source files
------------

// File: rtl/msrv32_ahb_pkg.sv
// Shared AHB-Lite encodings for the msrv32 instruction-bus slaves.
package msrv32_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // Data-phase state of the responder: idle, read data phase, two-cycle ERROR.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_ERR1 = 2'b10,
      ST_ERR2 = 2'b11
   } ahb_state_e;

endpackage

// File: rtl/msrv32_imem_ahb_responder.sv
// AHB-Lite read-only instruction memory responder. Decodes address phases from
// the fetch master, drives a 1-cycle-latency sync SRAM and returns the data with
// programmable wait states; illegal transfers get a two-cycle ERROR response.
// BASE_ADDR is expected to be word aligned.
module msrv32_imem_ahb_responder
   import msrv32_ahb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              hsel_in,
   input  logic [31:0]       haddr_in,
   input  logic [1:0]        htrans_in,
   input  logic              hwrite_in,
   input  logic [2:0]        hsize_in,
   input  logic              hready_in,
   output logic [31:0]       hrdata_out,
   output logic              hreadyout_out,
   output logic              hresp_out,
   output logic              mem_en_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   input  logic [31:0]       mem_rdata_in
);

   localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_STATES);
   localparam logic [32:0] BASE_EXT   = {1'b0, BASE_ADDR};
   localparam logic [32:0] WINDOW_END = BASE_EXT + (33'd1 << (ADDR_W + 2));

   ahb_state_e  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [32:0] addr_ext;
   logic        in_range;
   logic        legal;
   logic        accept;
   logic        ready_int;

   // Classify the address phase on the bus; the 33-bit compare makes a window that wraps past 4 GiB count as out of range.
   always_comb begin
      addr_ext = {1'b0, haddr_in};
      in_range = (addr_ext >= BASE_EXT) && (addr_ext < WINDOW_END);
      legal    = !hwrite_in && (haddr_in[1:0] == 2'b00) &&
                 (hsize_in == HSIZE_WORD) && in_range;
   end

   // Data-phase response, derived only from the registered phase state.
   always_comb begin
      ready_int  = 1'b1;
      hresp_out  = HRESP_OKAY;
      hrdata_out = '0;
      unique case (state_q)
         ST_DATA: begin
            ready_int = (wait_cnt_q == 4'd0);
            if (wait_cnt_q == 4'd0) begin
               hrdata_out = mem_rdata_in;
            end
         end
         ST_ERR1: begin
            ready_int = 1'b0;
            hresp_out = HRESP_ERROR;
         end
         ST_ERR2: begin
            hresp_out = HRESP_ERROR;
         end
         default: begin
         end
      endcase
   end

   assign hreadyout_out = ready_int;

   // Address phases are taken only while this slave ends its data phase; the SRAM read is issued in the same cycle.
   always_comb begin
      accept       = ready_int && hsel_in && hready_in &&
                     ((htrans_in == HTRANS_NONSEQ) || (htrans_in == HTRANS_SEQ));
      mem_en_out   = rst_n_in && accept && legal;
      mem_addr_out = haddr_in[ADDR_W+1:2] - BASE_ADDR[ADDR_W+1:2];
   end

   // Next-state: count down wait states, step through ERROR, otherwise follow the newly accepted transfer.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      if ((state_q == ST_DATA) && (wait_cnt_q != 4'd0)) begin
         wait_cnt_d = wait_cnt_q - 4'd1;
      end else if (state_q == ST_ERR1) begin
         state_d    = ST_ERR2;
         wait_cnt_d = 4'd0;
      end else if (accept && legal) begin
         state_d    = ST_DATA;
         wait_cnt_d = WAIT_LOAD;
      end else if (accept) begin
         state_d    = ST_ERR1;
         wait_cnt_d = 4'd0;
      end else begin
         state_d    = ST_IDLE;
         wait_cnt_d = 4'd0;
      end
   end

   // Phase state and wait counter registers.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule
